// File: rtl/coffee_pkg.sv
// Shared definitions for the coffee machine: display-visible state codes
// and reservoir sizing, also imported by the seven-segment display controller.
package coffee_pkg;

    localparam int unsigned STATE_W          = 3;
    localparam int unsigned CUP_W            = 2;
    localparam int unsigned MAX_CUPS_DEFAULT = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 3'b000,
        ST_READY      = 3'b001,
        ST_MAKING     = 3'b010,
        ST_DONE       = 3'b011,
        ST_NEED_WATER = 3'b100
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Up-counter with synchronous clear; expire pulses for one cycle when the
// count equals the terminal value, after which the count wraps to zero.
module cycle_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] terminal_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign expire_o = en_i && (count_q == terminal_i);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = expire_o ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/coffee_controller.sv
// Main sequencing FSM for the coffee machine: cup presence, start/refill,
// brew and done timing, and the reservoir cup counter.
module coffee_controller
    import coffee_pkg::*;
#(
    parameter int unsigned BREW_CYCLES = 500_000_000,
    parameter int unsigned DONE_CYCLES = 300_000_000,
    parameter int unsigned MAX_CUPS    = MAX_CUPS_DEFAULT
) (
    input  logic               clk_100MHz,
    input  logic               reset_n,
    input  logic               cup_sw,
    input  logic               start,
    input  logic               refill,
    output logic [STATE_W-1:0] state,
    output logic [CUP_W-1:0]   cup_count,
    output logic               brewing
);

    localparam int unsigned TMR_W = $clog2(max_u(BREW_CYCLES, DONE_CYCLES));
    localparam logic [TMR_W-1:0] BREW_TERM = TMR_W'(BREW_CYCLES - 1);
    localparam logic [TMR_W-1:0] DONE_TERM = TMR_W'(DONE_CYCLES - 1);
    localparam logic [CUP_W-1:0] FULL      = CUP_W'(MAX_CUPS);

    state_e             state_q, state_d;
    logic [CUP_W-1:0]   cups_q, cups_d;
    logic               done_q, done_d;
    logic               brewing_q, brewing_d;

    logic               tmr_en;
    logic               tmr_clear;
    logic [TMR_W-1:0]   tmr_term;
    logic               tmr_expire;

    cycle_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk_i      (clk_100MHz),
        .rst_ni     (reset_n),
        .clear_i    (tmr_clear),
        .en_i       (tmr_en),
        .terminal_i (tmr_term),
        .expire_o   (tmr_expire)
    );

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cups_q    <= FULL;
            done_q    <= 1'b0;
            brewing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cups_q    <= cups_d;
            done_q    <= done_d;
            brewing_q <= brewing_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cups_d  = cups_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (refill) cups_d = FULL;
                if (cup_sw) state_d = ST_READY;
            end
            ST_READY: begin
                // A simultaneous refill swallows the start pulse.
                if (refill) cups_d = FULL;
                if (!cup_sw) begin
                    state_d = ST_IDLE;
                end else if (start && !refill) begin
                    state_d = ST_MAKING;
                end
            end
            ST_MAKING: begin
                if (!cup_sw) begin
                    state_d = ST_IDLE;
                end else if (tmr_expire) begin
                    state_d = ST_DONE;
                    if (cups_q != '0) cups_d = cups_q - CUP_W'(1);
                end
            end
            ST_DONE: begin
                done_d = done_q || tmr_expire;
                if (done_d && !cup_sw) begin
                    done_d  = 1'b0;
                    state_d = (cups_q == '0) ? ST_NEED_WATER : ST_IDLE;
                end
            end
            ST_NEED_WATER: begin
                if (refill) begin
                    cups_d  = FULL;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Any state change restarts the timer, so DONE begins counting from zero.
    always_comb begin
        tmr_en    = (state_q == ST_MAKING) || (state_q == ST_DONE);
        tmr_clear = !tmr_en || (state_d != state_q);
        tmr_term  = (state_q == ST_MAKING) ? BREW_TERM : DONE_TERM;
        brewing_d = (state_d == ST_MAKING);
    end

    assign state     = state_q;
    assign cup_count = cups_q;
    assign brewing   = brewing_q;

endmodule

// File: tb/tb_coffee_controller.sv
// Directed bench for coffee_controller with short brew/done phases.
module tb_coffee_controller;
    import coffee_pkg::*;

    localparam int unsigned BREW = 10;
    localparam int unsigned DONE = 5;
    localparam int unsigned CUPS = 3;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       cup_sw = 1'b0;
    logic       start  = 1'b0;
    logic       refill = 1'b0;
    logic [2:0] state;
    logic [1:0] cup_count;
    logic       brewing;

    always #5 clk = ~clk;

    coffee_controller #(
        .BREW_CYCLES (BREW),
        .DONE_CYCLES (DONE),
        .MAX_CUPS    (CUPS)
    ) dut (
        .clk_100MHz (clk),
        .reset_n    (rst_n),
        .cup_sw     (cup_sw),
        .start      (start),
        .refill     (refill),
        .state      (state),
        .cup_count  (cup_count),
        .brewing    (brewing)
    );

    typedef struct {
        logic cup;
        logic st;
        logic rf;
        int   est;
        int   ecup;
        int   ebr;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int st, input int cups, input int br);
        check({tag, " state"}, int'(state), st);
        check({tag, " cup_count"}, int'(cup_count), cups);
        check({tag, " brewing"}, int'(brewing), br);
    endtask

    task automatic step(input logic c, input logic s, input logic r);
        cup_sw = c;
        start  = s;
        refill = r;
        @(posedge clk);
        #1;
        start  = 1'b0;
        refill = 1'b0;
    endtask

    function automatic void add(input logic c, input logic s, input logic r,
                                input int est, input int ecup, input int ebr);
        vec_t v;
        v.cup = c; v.st = s; v.rf = r; v.est = est; v.ecup = ecup; v.ebr = ebr;
        vecs.push_back(v);
    endfunction

    task automatic brew(input int pre, input int exit_st);
        step(1, 0, 0); check_out("brew ready", ST_READY, pre, 0);
        step(1, 1, 0); check_out("brew start", ST_MAKING, pre, 1);
        for (int i = 1; i < int'(BREW); i++) begin
            step(1, 0, 0); check_out("brew making", ST_MAKING, pre, 1);
        end
        step(1, 0, 0); check_out("brew done", ST_DONE, pre - 1, 0);
        for (int i = 0; i < int'(DONE); i++) begin
            step(1, 0, 0); check_out("brew hold", ST_DONE, pre - 1, 0);
        end
        step(0, 0, 0); check_out("brew exit", exit_st, pre - 1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout, required $finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", ST_IDLE, 3, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic brew, refill+start in READY, refill in MAKING/DONE, early cup removal in DONE.
        add(0, 0, 0, ST_IDLE, 3, 0);
        add(1, 0, 0, ST_READY, 3, 0);
        add(1, 1, 0, ST_MAKING, 3, 1);
        for (int i = 0; i < 9; i++) add(1, 0, 0, ST_MAKING, 3, 1);
        add(1, 0, 0, ST_DONE, 2, 0);
        for (int i = 0; i < 5; i++) add(1, 0, 0, ST_DONE, 2, 0);
        add(0, 0, 0, ST_IDLE, 2, 0);
        add(1, 0, 0, ST_READY, 2, 0);
        add(1, 1, 1, ST_READY, 3, 0);
        add(1, 0, 0, ST_READY, 3, 0);
        add(1, 1, 0, ST_MAKING, 3, 1);
        for (int i = 0; i < 4; i++) add(1, 0, 0, ST_MAKING, 3, 1);
        add(1, 0, 1, ST_MAKING, 3, 1);
        for (int i = 0; i < 4; i++) add(1, 0, 0, ST_MAKING, 3, 1);
        add(1, 0, 0, ST_DONE, 2, 0);
        add(1, 0, 0, ST_DONE, 2, 0);
        add(0, 0, 1, ST_DONE, 2, 0);
        add(0, 0, 0, ST_DONE, 2, 0);
        add(0, 0, 0, ST_DONE, 2, 0);
        add(0, 0, 0, ST_IDLE, 2, 0);
        add(0, 0, 1, ST_IDLE, 3, 0);
        add(0, 1, 0, ST_IDLE, 3, 0);

        foreach (vecs[i]) begin
            step(vecs[i].cup, vecs[i].st, vecs[i].rf);
            check_out($sformatf("vec%0d", i), vecs[i].est, vecs[i].ecup, vecs[i].ebr);
        end

        // Drain the reservoir, then recover through NEED_WATER.
        brew(3, ST_IDLE);
        brew(2, ST_IDLE);
        brew(1, ST_NEED_WATER);
        step(1, 1, 0); check_out("need_water start", ST_NEED_WATER, 0, 0);
        step(0, 0, 1); check_out("need_water refill", ST_IDLE, 3, 0);

        // Abort partway through MAKING and exactly on the expiry cycle.
        step(1, 0, 0); check_out("abort ready", ST_READY, 3, 0);
        step(1, 1, 0); check_out("abort start", ST_MAKING, 3, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        step(0, 0, 0); check_out("abort mid", ST_IDLE, 3, 0);
        step(1, 0, 0); check_out("abort2 ready", ST_READY, 3, 0);
        step(1, 1, 0); check_out("abort2 start", ST_MAKING, 3, 1);
        for (int i = 1; i < int'(BREW); i++) step(1, 0, 0);
        check_out("abort2 last", ST_MAKING, 3, 1);
        step(0, 0, 0); check_out("abort at expiry", ST_IDLE, 3, 0);
        step(0, 0, 0); check_out("abort settle", ST_IDLE, 3, 0);

        // Asynchronous reset in the middle of a brew with a partly used reservoir.
        brew(3, ST_IDLE);
        step(1, 0, 0); check_out("rst ready", ST_READY, 2, 0);
        step(1, 1, 0); check_out("rst start", ST_MAKING, 2, 1);
        step(1, 0, 0);
        step(1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async reset", ST_IDLE, 3, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        cup_sw = 1'b0;
        step(0, 0, 0); check_out("post reset", ST_IDLE, 3, 0);
        brew(3, ST_IDLE);

        // Illegal code recovers to IDLE on the next clock.
        @(negedge clk);
        force dut.state_q = state_e'(3'b110);
        #1;
        release dut.state_q;
        @(posedge clk);
        #1;
        check_out("illegal recover", ST_IDLE, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/coffee_controller.md
# coffee_controller

Main sequencing FSM for the coffee machine on the BASYS 3 board. It tracks the water reservoir in cups, reacts to the cup-present switch and the start/refill buttons, and times the brew and done phases. It drives the 3-bit `state` and 2-bit `cup_count` buses consumed by the seven-segment display controller and a brewing LED.

## Interface
Parameters:
- `BREW_CYCLES`, default 500_000_000: length of the brew phase in clocks (5 s at 100 MHz); must be ≥ 2.
- `DONE_CYCLES`, default 300_000_000: minimum time in DONE, in clocks (3 s); must be ≥ 2.
- `MAX_CUPS`, default 3: reservoir capacity and refill value; range 1–3.

Ports:
- `clk_100MHz`  in  1  BASYS 3 100 MHz clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cup_sw`  in  1  cup-present switch level, already synchronised; 1 = cup in place.
- `start`  in  1  single-cycle pulse from the upstream debouncer: start brew.
- `refill`  in  1  single-cycle pulse from the upstream debouncer: reservoir refilled.
- `state`  out  3  FSM state code for the display.
- `cup_count`  out  2  cups of water remaining.
- `brewing`  out  1  high while in MAKING.

## Operation
- State codes are fixed by the display decode: IDLE=000, READY=001, MAKING=010, DONE=011, NEED_WATER=100. Codes 101–111 are illegal and recover to IDLE on the next clock.
- IDLE → READY when `cup_sw`=1.
- READY → IDLE when `cup_sw`=0.
- READY → MAKING on `start` while `cup_sw`=1. The timer clears on entry.
- MAKING → DONE when the timer reaches BREW_CYCLES−1. `cup_count` decrements on the same edge.
- MAKING → IDLE (abort) when `cup_sw`=0. There is no decrement. Abort has priority over timer expiry in the same cycle.
- DONE: the timer restarts on entry. DONE exits only when the timer has reached DONE_CYCLES−1 (sticky flag) and `cup_sw`=0.
  - Exit goes to NEED_WATER if `cup_count`=0, otherwise to IDLE.
- NEED_WATER → IDLE on `refill`.
- Refill handling:
  - `refill` in IDLE, READY or NEED_WATER loads `cup_count`=MAX_CUPS.
  - `refill` is ignored in MAKING and DONE.
  - If `refill` and `start` arrive together in READY, refill wins: the count reloads, the state stays READY, and `start` is dropped.
- `start` is ignored outside READY.
- `cup_count` never underflows. MAKING is unreachable with a count of 0 because DONE routes to NEED_WATER.
- `brewing` is a registered decode of state == MAKING.

## Timing
- Reset values: `state`=000 (IDLE), `cup_count`=MAX_CUPS, `brewing`=0, timer=0, done flag=0.
- All outputs are registered. An input sampled at edge N is reflected on the outputs after edge N.
- MAKING lasts exactly BREW_CYCLES clocks when not aborted. DONE lasts at least DONE_CYCLES clocks.
- Timer width is $clog2(max(BREW_CYCLES, DONE_CYCLES)). The timer holds at 0 in IDLE, READY and NEED_WATER.
- Asserting `reset_n` mid-brew returns the block to IDLE with a full reservoir immediately. No partial decrement is retained.

## Structure
- Package `coffee_pkg`:
  - state enum/localparams (the display-visible encodings above);
  - `MAX_CUPS` default;
  - the `cup_count` width constant.
  The display controller imports the same package.
- Sub-module `cycle_timer`: an up-counter with synchronous clear, a terminal-value input and a single-cycle `expire` output, reused for the brew and done phases.
- The FSM and cup counter live in `coffee_controller`.

## Test plan
All scenarios run with BREW_CYCLES=10, DONE_CYCLES=5 and MAX_CUPS=3.
1. Reset release, `cup_sw`=1, `start` pulse → IDLE, READY, then MAKING for exactly 10 clocks with `brewing`=1; DONE with `cup_count` 3→2; after ≥5 clocks drop `cup_sw` → IDLE.
2. Three full brews → `cup_count` 0; on cup removal after the third DONE → `state`=100. Then `refill` → IDLE, `cup_count`=3.
3. Drop `cup_sw` at clock 4 of MAKING → IDLE next clock, `cup_count` unchanged. Also drop `cup_sw` exactly on the expiry cycle → IDLE, no decrement.
4. Remove the cup 2 clocks into DONE → stays DONE until the 5-clock minimum elapses, then IDLE.
5. `refill` and `start` in the same cycle in READY → stays READY, `cup_count`=3. `refill` during MAKING → ignored, count still decrements.
6. Assert `reset_n` mid-MAKING → outputs immediately 000/3/0. Force illegal state 110 → IDLE after one clock.
